fwd_ctrl: RTL and testbench



---
 rtl/fwd_ctrl.sv | 89 ++++++++
 tb/tb_fwd_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller: tracks EX/MEM destination tags,
// registers the EX operand-mux selects and raises the one-cycle load-use stall.
module fwd_ctrl #(
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic            c,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic            id_we,
   input  logic            id_ld,
   input  logic            id_imm,
   input  logic            flush,
   output logic [1:0]      sel_a,
   output logic [1:0]      sel_b,
   output logic            stall,
   output logic [CNTW-1:0] stall_cnt
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;
   localparam logic [1:0] SEL_IMM = 2'b11;

   logic            ex_v, ex_we, ex_ld;
   logic [REGW-1:0] ex_rd;
   logic            mem_v, mem_we;
   logic [REGW-1:0] mem_rd;

   logic hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2;
   logic take;
   logic [1:0] sel_a_nxt, sel_b_nxt;

   // Register 0 is hardwired, so a write to it is never a forwarding source.
   always_comb begin
      hit_ex_rs1  = ex_v  & ex_we  & (ex_rd  == id_rs1) & (id_rs1 != '0);
      hit_ex_rs2  = ex_v  & ex_we  & (ex_rd  == id_rs2) & (id_rs2 != '0);
      hit_mem_rs1 = mem_v & mem_we & (mem_rd == id_rs1) & (id_rs1 != '0);
      hit_mem_rs2 = mem_v & mem_we & (mem_rd == id_rs2) & (id_rs2 != '0);
   end

   // Operand B of an immediate instruction does not read rs2, so it cannot stall.
   assign stall = id_valid & ex_v & ex_ld & (hit_ex_rs1 | (hit_ex_rs2 & ~id_imm)) & ~flush;
   assign take  = id_valid & ~stall & ~flush;

   always_comb begin
      sel_a_nxt = SEL_RF;
      sel_b_nxt = SEL_RF;
      if (take) begin
         if (hit_ex_rs1)       sel_a_nxt = SEL_EX;
         else if (hit_mem_rs1) sel_a_nxt = SEL_MEM;
         if (id_imm)           sel_b_nxt = SEL_IMM;
         else if (hit_ex_rs2)  sel_b_nxt = SEL_EX;
         else if (hit_mem_rs2) sel_b_nxt = SEL_MEM;
      end
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         ex_v      <= 1'b0;
         ex_we     <= 1'b0;
         ex_ld     <= 1'b0;
         ex_rd     <= '0;
         mem_v     <= 1'b0;
         mem_we    <= 1'b0;
         mem_rd    <= '0;
         sel_a     <= SEL_RF;
         sel_b     <= SEL_RF;
         stall_cnt <= '0;
      end else begin
         mem_v  <= ex_v;
         mem_we <= ex_we;
         mem_rd <= ex_rd;
         // A stall or flush injects a bubble; clearing ex_ld guarantees a one-cycle stall.
         ex_v   <= take;
         ex_we  <= take & id_we;
         ex_ld  <= take & id_ld;
         ex_rd  <= id_rd;
         sel_a  <= sel_a_nxt;
         sel_b  <= sel_b_nxt;
         if (stall && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: hand-computed select/stall/counter values for
// forwarding, priority, load-use, immediate, flush, reset and saturation cases.
module tb_fwd_ctrl;

   localparam int REGW = 5;
   localparam int CNTW = 4;

   logic            c;
   logic            rst_n;
   logic            id_valid;
   logic [REGW-1:0] id_rs1, id_rs2, id_rd;
   logic            id_we, id_ld, id_imm, flush;
   logic [1:0]      sel_a, sel_b;
   logic            stall;
   logic [CNTW-1:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cnt = 0;

   fwd_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
      .c(c), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_we(id_we), .id_ld(id_ld), .id_imm(id_imm), .flush(flush),
      .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .stall_cnt(stall_cnt)
   );

   // clock / reset
   initial c = 1'b0;
   always #5 c = ~c;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the active edge; outputs are sampled there too.
   task automatic tick();
      @(posedge c);
      #1;
   endtask

   task automatic set_id(input logic v, input int rs1, input int rs2, input int rd,
                         input logic we, input logic ld, input logic imm);
      id_valid = v;
      id_rs1   = REGW'(rs1);
      id_rs2   = REGW'(rs2);
      id_rd    = REGW'(rd);
      id_we    = we;
      id_ld    = ld;
      id_imm   = imm;
      #1;
   endtask

   task automatic nop();
      set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_sels(input string tag, input logic [1:0] ea, input logic [1:0] eb);
      check({tag, "_sel_a"}, 32'(sel_a), 32'(ea));
      check({tag, "_sel_b"}, 32'(sel_b), 32'(eb));
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      nop();
      #1;
      check_sels("reset", 2'b00, 2'b00);
      check("reset_stall", 32'(stall), 0);
      check("reset_cnt", 32'(stall_cnt), 0);
      tick();
      rst_n = 1'b1;

      // EX forward: ADD r3,r1,r2 ; SUB r5,r3,r4
      set_id(1, 1, 2, 3, 1, 0, 0); tick();
      set_id(1, 3, 4, 5, 1, 0, 0);
      check("exfwd_stall", 32'(stall), 0);
      tick();
      check_sels("exfwd", 2'b01, 2'b00);
      nop(); tick();
      check_sels("nop", 2'b00, 2'b00);

      // MEM forward: ADD r3 ; NOP ; OR r6,r3,r3
      set_id(1, 1, 2, 3, 1, 0, 0); tick();
      nop(); tick();
      set_id(1, 3, 3, 6, 1, 0, 0); tick();
      check_sels("memfwd", 2'b10, 2'b10);

      // Priority: ADD r3 ; ADD r3 ; OR r6,r3,r0
      set_id(1, 1, 2, 3, 1, 0, 0); tick();
      set_id(1, 1, 2, 3, 1, 0, 0); tick();
      set_id(1, 3, 0, 6, 1, 0, 0); tick();
      check_sels("prio", 2'b01, 2'b00);

      // Load-use: LW r7,(r1) ; ADD r8,r7,r1
      set_id(1, 1, 0, 7, 1, 1, 0); tick();
      set_id(1, 7, 1, 8, 1, 0, 0);
      check("lu_stall", 32'(stall), 1);
      tick(); exp_cnt++;
      check_sels("lu_bubble", 2'b00, 2'b00);
      check("lu_cnt", 32'(stall_cnt), 32'(exp_cnt));
      check("lu_stall_drop", 32'(stall), 0);
      tick();
      check_sels("lu_consumer", 2'b10, 2'b00);

      // Immediate: rs2 field matches the load but is unused
      set_id(1, 1, 0, 7, 1, 1, 0); tick();
      set_id(1, 1, 7, 2, 1, 0, 1);
      check("imm_rs2_nostall", 32'(stall), 0);
      tick();
      check_sels("imm_rs2", 2'b00, 2'b11);

      // ADDI r2,r7,#4 after LW r7
      set_id(1, 1, 0, 7, 1, 1, 0); tick();
      set_id(1, 7, 0, 2, 1, 0, 1);
      check("imm_stall", 32'(stall), 1);
      tick(); exp_cnt++;
      check_sels("imm_bubble", 2'b00, 2'b00);
      check("imm_stall_drop", 32'(stall), 0);
      tick();
      check_sels("imm_consumer", 2'b10, 2'b11);
      check("imm_cnt", 32'(stall_cnt), 32'(exp_cnt));

      // Back-to-back loads: LW r7 ; LW r9,(r7) ; ADD r10,r9,r0
      set_id(1, 1, 0, 7, 1, 1, 0); tick();
      set_id(1, 7, 0, 9, 1, 1, 0);
      check("b2b_stall1", 32'(stall), 1);
      tick(); exp_cnt++;
      check("b2b_drop1", 32'(stall), 0);
      tick();
      check_sels("b2b_ld2", 2'b10, 2'b00);
      set_id(1, 9, 0, 10, 1, 0, 0);
      check("b2b_stall2", 32'(stall), 1);
      tick(); exp_cnt++;
      check("b2b_drop2", 32'(stall), 0);
      tick();
      check_sels("b2b_add", 2'b10, 2'b00);
      check("b2b_cnt", 32'(stall_cnt), 32'(exp_cnt));

      // Flush with a load-use pair in EX/ID
      set_id(1, 1, 0, 7, 1, 1, 0); tick();
      flush = 1'b1;
      set_id(1, 7, 1, 8, 1, 0, 0);
      check("flush_stall", 32'(stall), 0);
      tick();
      flush = 1'b0;
      check_sels("flush_bubble", 2'b00, 2'b00);
      check("flush_cnt", 32'(stall_cnt), 32'(exp_cnt));
      set_id(1, 8, 0, 11, 1, 0, 0); tick();
      check_sels("flush_killed", 2'b00, 2'b00);

      // Asynchronous reset mid-cycle while a stall is pending
      set_id(1, 1, 0, 7, 1, 1, 0); tick();
      set_id(1, 7, 0, 8, 1, 0, 0);
      check("pre_reset_stall", 32'(stall), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_sels("async_reset", 2'b00, 2'b00);
      check("async_reset_stall", 32'(stall), 0);
      check("async_reset_cnt", 32'(stall_cnt), 0);
      exp_cnt = 0;

      // Release mid-stream: the first edge shifts ID into EX normally
      set_id(1, 1, 2, 3, 1, 0, 0);
      rst_n = 1'b1;
      tick();
      set_id(1, 3, 3, 4, 1, 0, 0);
      check("release_stall", 32'(stall), 0);
      tick();
      check_sels("release_fwd", 2'b01, 2'b01);

      // Saturation: 17 load-use pairs on a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         set_id(1, 1, 0, 7, 1, 1, 0); tick();
         set_id(1, 7, 1, 8, 1, 0, 0);
         if (i == 0 || i == 16) check("sat_stall", 32'(stall), 1);
         tick();
         if (exp_cnt < 15) exp_cnt++;
         tick();
         if (i == 14) check("sat_cnt15", 32'(stall_cnt), 15);
      end
      check("sat_cnt_hold", 32'(stall_cnt), 32'(exp_cnt));
      check("sat_cnt_final", 32'(stall_cnt), 15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
